sram_array_ctrl: RTL and testbench

//  Initiator for a single-port, 1-cycle-read-latency masked-write SRAM macro (2048x42, 6 lanes x 7b).

---
 rtl/sram_array_ctrl_if.sv | 28 ++
 rtl/sram_array_ctrl.sv | 114 +++++++++++
 tb/tb_sram_array_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sram_array_ctrl_if.sv
// sram_array_ctrl_if: write/read request channels and read response channel of the SRAM controller
interface sram_array_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 42,
    parameter int MASK_W = 6
);
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [MASK_W-1:0] w_mask;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output w_valid, w_addr, w_data, w_mask, r_valid, r_addr, resp_ready,
        input  w_ready, r_ready, resp_valid, resp_data
    );

    modport slave (
        input  w_valid, w_addr, w_data, w_mask, r_valid, r_addr, resp_ready,
        output w_ready, r_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl: arbitrates write/read requests onto a 1-cycle-latency masked-write SRAM, zero-fills after reset
module sram_array_ctrl #(
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 42,
    parameter int MASK_W        = 6,
    parameter int INIT_ON_RESET = 1,
    parameter int STARVE_MAX    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    sram_array_ctrl_if.slave  bus,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              pop, rd_ok, force_rd, wr_gnt, rd_gnt;

    // Reads are only admitted while the FIFO can still absorb every outstanding response.
    assign pop      = bus.resp_valid & bus.resp_ready;
    assign rd_ok    = ({1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    assign force_rd = bus.r_valid & rd_ok & (starve_cnt == SW'(STARVE_MAX));
    // Grants are masked while reset is held so every output reads 0 immediately on assertion.
    assign wr_gnt   = reset_n & (state == RUN) & bus.w_valid & ~force_rd;
    assign rd_gnt   = reset_n & (state == RUN) & bus.r_valid & rd_ok & ~wr_gnt;

    assign bus.w_ready    = wr_gnt;
    assign bus.r_ready    = rd_gnt;
    assign bus.resp_valid = fifo_cnt != 2'd0;
    assign bus.resp_data  = bus.resp_valid ? fifo_mem[rd_ptr] : '0;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= (INIT_ON_RESET != 0) ? INIT : RUN;
        else          state <= state_next;
    end

    // Next state and macro port drive: init sweep, else the single granted request.
    always_comb begin
        state_next = (state == INIT && &init_cnt) ? RUN : state;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (reset_n && state == INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_cnt;
            sram_wmask = '1;
        end else if (wr_gnt) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = bus.w_addr;
            sram_wmask = bus.w_mask;
            sram_wdata = bus.w_data;
        end else if (rd_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = bus.r_addr;
        end
    end

    // Init address sweep and the sticky done flag raised once RUN is entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            init_done <= state_next == RUN;
        end
    end

    // Count write wins over a waiting, admissible read; a read grant or a dropped read clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                        starve_cnt <= '0;
        else if (rd_gnt || !bus.r_valid)     starve_cnt <= '0;
        else if (wr_gnt && rd_ok && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end

    // Read data arrives the cycle after issue and is captured into the 2-entry response FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            inflight <= rd_gnt;
            if (inflight) begin
                fifo_mem[wr_ptr] <= sram_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_sram_array_ctrl.sv
// tb_sram_array_ctrl: directed bench with an SRAM macro model, reference memory and response scoreboard
module tb_sram_array_ctrl;
    localparam int AW = 11;
    localparam int DW = 42;
    localparam int MW = 6;
    localparam int LW = DW / MW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          init_done, sram_en, sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic [DW-1:0] sram_mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] sb [$];
    int            checks = 0;
    int            errors = 0;
    logic          last_w, last_r, last_rv;
    logic [DW-1:0] last_rd;
    logic [60:0]   last_port;

    sram_array_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

    sram_array_ctrl dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // SRAM macro: masked write, registered read data valid the cycle after a read.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MW; l++)
                    if (sram_wmask[l]) sram_mem[sram_addr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic [DW-1:0] r = old;
        for (int l = 0; l < MW; l++) if (m[l]) r[l*LW +: LW] = d[l*LW +: LW];
        return r;
    endfunction

    function automatic logic [127:0] outs();
        return {init_done, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
                bus.w_ready, bus.r_ready, bus.resp_valid, bus.resp_data};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int a = 0; a < 2**AW; a++) ref_mem[a] = '0;
    endtask

    // One cycle: sample at negedge, score responses, track grants, return at posedge+1.
    task automatic cyc();
        @(negedge clock);
        last_w    = bus.w_ready;
        last_r    = bus.r_ready;
        last_rv   = bus.resp_valid;
        last_rd   = bus.resp_data;
        last_port = {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata};
        if (bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) check("resp_unexpected", bus.resp_valid, 1'b0);
            else                check("resp_data", bus.resp_data, sb.pop_front());
        end
        if (last_w) ref_mem[bus.w_addr] = merge(ref_mem[bus.w_addr], bus.w_data, bus.w_mask);
        if (last_r) sb.push_back(ref_mem[bus.r_addr]);
        @(posedge clock);
        #1;
    endtask

    task automatic init_step(input int i);
        @(negedge clock);
        check($sformatf("init_port_%0d", i), {sram_en, sram_wmode, sram_wmask, sram_wdata, sram_addr},
              {1'b1, 1'b1, 6'h3f, 42'h0, AW'(i)});
        check($sformatf("init_closed_%0d", i), {bus.w_ready, bus.r_ready, init_done}, 3'b000);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int wi, ri;
        bus.w_valid = 0; bus.w_addr = '0; bus.w_data = '0; bus.w_mask = '0;
        bus.r_valid = 0; bus.r_addr = '0; bus.resp_ready = 0;
        repeat (2) @(posedge clock);
        #1;
        bus.w_valid = 1; bus.r_valid = 1;
        @(negedge clock);
        check("reset_outs", outs(), '0);
        @(posedge clock);
        #1;
        reset_n = 1;
        clear_ref();
        for (int i = 0; i < 256; i++) init_step(i);
        check("init_cnt_100", sram_addr, AW'(12'h100));
        reset_n = 0;
        #1;
        check("reset_mid_init", outs(), '0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;
        clear_ref();
        for (int i = 0; i < 2**AW; i++) begin
            bus.w_valid = i < 2**AW - 1;
            bus.r_valid = i < 2**AW - 1;
            init_step(i);
        end
        @(negedge clock);
        check("init_done_idle", {init_done, sram_en}, 2'b10);
        @(posedge clock);
        #1;

        bus.w_valid = 1; bus.w_addr = 11'h010; bus.w_data = 42'h3FF_FFFF_FFFF; bus.w_mask = 6'b000001;
        cyc();
        check("wr_port", last_port, {1'b1, 1'b1, 11'h010, 6'h01, 42'h3FF_FFFF_FFFF});
        bus.w_valid = 0; bus.r_valid = 1; bus.r_addr = 11'h010; bus.resp_ready = 1;
        cyc();
        check("rd_grant", {last_w, last_r}, 2'b01);
        check("rd_port", last_port, {1'b1, 1'b0, 11'h010, 6'h00, 42'h0});
        bus.r_valid = 0;
        cyc();
        check("rv_t1", last_rv, 1'b0);
        cyc();
        check("rv_t2", last_rv, 1'b1);
        check("resp_7f", last_rd, 42'h0000000007F);

        wi = 0; ri = 0;
        bus.w_valid = 1; bus.r_valid = 1;
        bus.w_data = {10'($urandom), $urandom}; bus.w_mask = 6'($urandom);
        for (int k = 0; k < 10; k++) begin
            bus.w_addr = AW'(12'h100 + wi);
            bus.r_addr = AW'(12'h100 + ri);
            cyc();
            check($sformatf("arb_%0d", k), {last_w, last_r}, (k % 5 == 4) ? 2'b01 : 2'b10);
            if (last_w) begin
                wi++;
                bus.w_data = {10'($urandom), $urandom};
                bus.w_mask = 6'($urandom);
            end
            if (last_r) ri++;
        end
        bus.w_valid = 0; bus.r_valid = 0;
        repeat (3) cyc();

        bus.resp_ready = 0; bus.r_valid = 1; ri = 0;
        for (int k = 0; k < 4; k++) begin
            bus.r_addr = AW'(12'h101 + ri);
            cyc();
            check($sformatf("bp_grant_%0d", k), last_r, k < 2);
            if (last_r) ri++;
        end
        bus.resp_ready = 1;
        bus.r_addr = AW'(12'h101 + ri);
        cyc();
        check("bp_resume", last_r, 1'b1);
        bus.r_valid = 0;
        repeat (4) cyc();
        check("sb_drained_bp", sb.size(), 0);

        for (int j = 0; j < 8; j++) begin
            bus.w_valid = 1; bus.w_addr = AW'(j + 1); bus.w_mask = 6'h3f;
            bus.w_data = DW'(64'h1111 * (j + 1)) | (DW'(j) << 36);
            cyc();
            check($sformatf("b2b_wr_%0d", j), last_w, 1'b1);
        end
        bus.w_valid = 0;
        for (int j = 0; j < 12; j++) begin
            bus.r_valid = j < 8;
            bus.r_addr = AW'(j + 1);
            cyc();
            check($sformatf("b2b_grant_%0d", j), last_r, j < 8);
            check($sformatf("b2b_rv_%0d", j), last_rv, j >= 2 && j <= 9);
        end
        check("sb_drained_b2b", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
